// File: rtl/bht_ckpt_ctrl.sv
// Branch history table checkpoint sequencer: freezes the BHT, walks every entry,
// packs 3-bit entries into 64-bit words and stores them through the dcache port.
module bht_ckpt_ctrl #(
  parameter int unsigned NR_ENTRIES       = 1024,
  parameter int unsigned ENTRIES_PER_WORD = 21
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [63:0]                   base_addr_i,
  output logic                          busy_o,
  output logic                          bht_freeze_o,
  output logic                          done_o,
  output logic [$clog2(NR_ENTRIES)-1:0] bht_rd_idx_o,
  input  logic [2:0]                    bht_rd_data_i,
  output logic                          req_o,
  input  logic                          gnt_i,
  output logic [63:0]                   addr_o,
  output logic [63:0]                   wdata_o,
  output logic [7:0]                    be_o,
  output logic [1:0]                    size_o
);

  localparam int unsigned IdxW  = $clog2(NR_ENTRIES);
  localparam int unsigned CntW  = IdxW + 1;
  localparam int unsigned SlotW = (ENTRIES_PER_WORD > 1) ? $clog2(ENTRIES_PER_WORD) : 1;

  localparam logic [CntW-1:0]  LastIdx  = CntW'(NR_ENTRIES - 1);
  localparam logic [CntW-1:0]  EndIdx   = CntW'(NR_ENTRIES);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(ENTRIES_PER_WORD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StWrite,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  idx_q, idx_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [63:0]      pack_q, pack_d;
  logic [63:0]      waddr_q, waddr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      slot_q  <= '0;
      pack_q  <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      pack_q  <= pack_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    pack_d  = pack_q;
    waddr_d = waddr_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = '0;
          slot_d  = '0;
          pack_d  = '0;
          waddr_d = {base_addr_i[63:3], 3'b000};
          state_d = StPack;
        end
      end

      StPack: begin
        pack_d[3*int'(slot_q) +: 3] = bht_rd_data_i;
        idx_d  = idx_q + 1'b1;
        slot_d = slot_q + 1'b1;
        // Close the word when it is full or the last entry has just been packed.
        if ((slot_q == LastSlot) || (idx_q == LastIdx)) begin
          state_d = StWrite;
        end
      end

      StWrite: begin
        // Everything stays frozen until the grant so the store is never torn.
        if (gnt_i) begin
          waddr_d = waddr_q + 64'd8;
          pack_d  = '0;
          slot_d  = '0;
          state_d = (idx_q == EndIdx) ? StDone : StPack;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy_o       = 1'b0;
    done_o       = 1'b0;
    req_o        = 1'b0;
    bht_rd_idx_o = '0;

    case (state_q)
      StPack: begin
        busy_o       = 1'b1;
        bht_rd_idx_o = idx_q[IdxW-1:0];
      end
      StWrite: begin
        busy_o = 1'b1;
        req_o  = 1'b1;
      end
      StDone: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign bht_freeze_o = busy_o;
  assign addr_o       = req_o ? waddr_q : 64'd0;
  assign wdata_o      = req_o ? pack_q : 64'd0;
  assign be_o         = req_o ? 8'hFF : 8'h00;
  assign size_o       = 2'b11;

endmodule

// File: tb/tb_bht_ckpt_ctrl.sv
// Randomized bench for bht_ckpt_ctrl: a BHT array model plus a store scoreboard
// compares the stored image, handshake stability and cycle timing.
module tb_bht_ckpt_ctrl;

  localparam int NrEntries = 1024;
  localparam int Epw       = 21;
  localparam int NrWords   = (NrEntries + Epw - 1) / Epw;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [63:0] base_addr_i;
  logic        busy_o;
  logic        bht_freeze_o;
  logic        done_o;
  logic [9:0]  bht_rd_idx_o;
  logic [2:0]  bht_rd_data_i;
  logic        req_o;
  logic        gnt_i;
  logic [63:0] addr_o;
  logic [63:0] wdata_o;
  logic [7:0]  be_o;
  logic [1:0]  size_o;

  bht_ckpt_ctrl #(
    .NR_ENTRIES      (NrEntries),
    .ENTRIES_PER_WORD(Epw)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .busy_o       (busy_o),
    .bht_freeze_o (bht_freeze_o),
    .done_o       (done_o),
    .bht_rd_idx_o (bht_rd_idx_o),
    .bht_rd_data_i(bht_rd_data_i),
    .req_o        (req_o),
    .gnt_i        (gnt_i),
    .addr_o       (addr_o),
    .wdata_o      (wdata_o),
    .be_o         (be_o),
    .size_o       (size_o)
  );

  logic [2:0] bht_mem [NrEntries];
  assign bht_rd_data_i = bht_mem[bht_rd_idx_o];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: word w holds entries w*Epw .. w*Epw+Epw-1, entry k at bits [3k+2:3k].
  function automatic logic [63:0] exp_word(input int w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < Epw; k++) begin
      if (w * Epw + k < NrEntries) r[3*k +: 3] = bht_mem[w * Epw + k];
    end
    return r;
  endfunction

  // Grant generator: random stall per store, optional gnt noise while idle.
  int gnt_max = 0;
  bit idle_gnt_hi = 1'b0;
  bit idle_gnt_rand = 1'b0;

  initial begin
    bit in_req;
    int wait_left;
    in_req = 1'b0;
    wait_left = 0;
    gnt_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (req_o) begin
        if (!in_req) begin
          in_req = 1'b1;
          wait_left = $urandom_range(gnt_max, 0);
        end
        gnt_i = (wait_left == 0);
        if (wait_left != 0) wait_left--;
      end else begin
        in_req = 1'b0;
        gnt_i = idle_gnt_rand ? 1'($urandom) : idle_gnt_hi;
      end
    end
  end

  // Monitor (sampled on the falling edge).
  bit          mon_en = 1'b0;
  int          cyc;
  logic [63:0] st_addr[$];
  logic [63:0] st_data[$];
  int          done_cyc[$];
  int          first_req_cyc, last_store_cyc, busy_low_cyc, busy_again_cyc;
  int          stab_err, freeze_err, proto_err;

  task automatic clear_mon();
    st_addr.delete();
    st_data.delete();
    done_cyc.delete();
    first_req_cyc  = -1;
    last_store_cyc = -1;
    busy_low_cyc   = -1;
    busy_again_cyc = -1;
    stab_err       = 0;
    freeze_err     = 0;
    proto_err      = 0;
  endtask

  initial begin
    bit          prev_stall;
    logic [63:0] prev_addr, prev_data;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        cyc++;
        if (prev_stall && (!req_o || addr_o !== prev_addr || wdata_o !== prev_data)) stab_err++;
        prev_stall = req_o && !gnt_i;
        prev_addr  = addr_o;
        prev_data  = wdata_o;
        if (be_o !== (req_o ? 8'hFF : 8'h00) || size_o !== 2'b11) proto_err++;
        if (busy_o !== bht_freeze_o) freeze_err++;
        if (cyc >= 1 && done_cyc.size() == 0 && !busy_o) freeze_err++;
        if (req_o && first_req_cyc < 0) first_req_cyc = cyc;
        if (req_o && gnt_i) begin
          st_addr.push_back(addr_o);
          st_data.push_back(wdata_o);
          last_store_cyc = cyc;
        end
        if (done_o) done_cyc.push_back(cyc);
        if (done_cyc.size() > 0 && !busy_o && busy_low_cyc < 0) busy_low_cyc = cyc;
        if (busy_low_cyc >= 0 && busy_o && busy_again_cyc < 0) busy_again_cyc = cyc;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic start_run(input logic [63:0] base, input int gmax, input bit hold);
    clear_mon();
    base_addr_i = base;
    gnt_max = gmax;
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    cyc = -1;
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done(input int ndone, input string tag);
    int budget;
    budget = 0;
    while (done_cyc.size() < ndone && budget < 20000) begin
      @(negedge clk_i);
      budget++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cyc.size()), 64'(ndone));
    repeat (3) @(negedge clk_i);
    mon_en = 1'b0;
  endtask

  task automatic check_image(input string tag, input logic [63:0] base, input int nruns);
    int img_err;
    int w;
    img_err = 0;
    check_eq({tag, "_nstores"}, 64'(st_addr.size()), 64'(nruns * NrWords));
    for (int i = 0; i < st_addr.size(); i++) begin
      w = i % NrWords;
      if (st_addr[i] !== {base[63:3], 3'b000} + 64'(8 * w)) img_err++;
      if (st_data[i] !== exp_word(w)) img_err++;
    end
    check_eq({tag, "_image"}, 64'(img_err), 64'd0);
    check_eq({tag, "_stable"}, 64'(stab_err), 64'd0);
    check_eq({tag, "_freeze"}, 64'(freeze_err), 64'd0);
    check_eq({tag, "_be_size"}, 64'(proto_err), 64'd0);
  endtask

  task automatic fill_random();
    for (int e = 0; e < NrEntries; e++) bht_mem[e] = 3'($urandom);
  endtask

  initial begin
    int reqs;
    int budget;
    rst_ni = 1'b0;
    start_i = 1'b0;
    base_addr_i = '0;
    for (int e = 0; e < NrEntries; e++) bht_mem[e] = 3'(e % 8);
    clear_mon();
    repeat (3) @(posedge clk_i);

    // Reset values, sampled while reset is still held.
    @(negedge clk_i);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_freeze", 64'(bht_freeze_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_req", 64'(req_o), 64'd0);
    check_eq("rst_addr", addr_o, 64'd0);
    check_eq("rst_wdata", wdata_o, 64'd0);
    check_eq("rst_be", 64'(be_o), 64'd0);
    check_eq("rst_rd_idx", 64'(bht_rd_idx_o), 64'd0);
    check_eq("rst_size", 64'(size_o), 64'd3);
    rst_ni = 1'b1;

    // Idle with start low and gnt noise: no store request may appear.
    idle_gnt_rand = 1'b1;
    reqs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (req_o || busy_o) reqs++;
    end
    check_eq("idle_no_req", 64'(reqs), 64'd0);

    // e%8 pattern with gnt effectively tied high: exact cycle timing.
    idle_gnt_rand = 1'b0;
    idle_gnt_hi = 1'b1;
    start_run(64'h8000_0000, 0, 1'b0);
    wait_done(1, "tied");
    check_image("tied", 64'h8000_0000, 1);
    check_eq("tied_first_req_cyc", 64'(first_req_cyc), 64'd22);
    check_eq("tied_last_store_cyc", 64'(last_store_cyc), 64'd1073);
    check_eq("tied_done_cyc", 64'(done_cyc[0]), 64'd1074);
    check_eq("tied_busy_low_cyc", 64'(busy_low_cyc), 64'd1075);
    check_eq("tied_addr_first", st_addr[0], 64'h8000_0000);
    check_eq("tied_addr_last", st_addr[NrWords-1], 64'h8000_0180);
    check_eq("tied_word0", st_data[0], exp_word(0));
    check_eq("tied_word48_hi", 64'(st_data[NrWords-1][63:48]), 64'd0);

    // Unaligned base is forced onto an 8-byte boundary.
    fill_random();
    idle_gnt_rand = 1'b1;
    start_run(64'h1005, 0, 1'b0);
    wait_done(1, "unal");
    check_eq("unal_addr_first", st_addr[0], 64'h1000);
    check_image("unal", 64'h1005, 1);

    // Random grant stalls of 0..7 cycles.
    for (int r = 0; r < 2; r++) begin
      fill_random();
      start_run({$urandom, $urandom}, 7, 1'b0);
      wait_done(1, "stall");
      check_image("stall", base_addr_i, 1);
    end

    // Start held high: one DONE per run, next run begins only after DONE.
    fill_random();
    idle_gnt_rand = 1'b0;
    start_run(64'h2000, 0, 1'b1);
    budget = 0;
    while (done_cyc.size() < 1 && budget < 5000) begin
      @(negedge clk_i);
      budget++;
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done(2, "hold");
    check_image("hold", 64'h2000, 2);
    check_eq("hold_done1_cyc", 64'(done_cyc[0]), 64'd1074);
    check_eq("hold_done2_cyc", 64'(done_cyc[1]), 64'd2149);
    check_eq("hold_busy_low_cyc", 64'(busy_low_cyc), 64'd1075);
    check_eq("hold_restart_cyc", 64'(busy_again_cyc), 64'd1076);

    // Reset while store 10 is pending, then a clean restart.
    fill_random();
    idle_gnt_rand = 1'b1;
    start_run(64'h4000, 3, 1'b0);
    budget = 0;
    while (!(st_addr.size() >= 10 && req_o) && budget < 5000) begin
      @(negedge clk_i);
      budget++;
    end
    check_eq("mid_reached_store10", 64'(req_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    mon_en = 1'b0;
    check_eq("mid_rst_busy", 64'(busy_o), 64'd0);
    check_eq("mid_rst_freeze", 64'(bht_freeze_o), 64'd0);
    check_eq("mid_rst_req", 64'(req_o), 64'd0);
    check_eq("mid_rst_addr", addr_o, 64'd0);
    check_eq("mid_rst_wdata", wdata_o, 64'd0);
    check_eq("mid_rst_be", 64'(be_o), 64'd0);
    check_eq("mid_rst_rd_idx", 64'(bht_rd_idx_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    start_run(64'h4000, 3, 1'b0);
    wait_done(1, "restart");
    check_eq("restart_addr_first", st_addr[0], 64'h4000);
    check_eq("restart_word0", st_data[0], exp_word(0));
    check_image("restart", 64'h4000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
